// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and flag-index definitions for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_NOTA = 4'b0100;
    localparam logic [3:0] OP_NOTB = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_DIV  = 4'b1010;
    localparam logic [3:0] OP_SHL  = 4'b1011;
    localparam logic [3:0] OP_SHR  = 4'b1100;
    localparam logic [3:0] OP_ROL  = 4'b1101;
    localparam logic [3:0] OP_ROR  = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int FLG_ZERO  = 0;
    localparam int FLG_NEG   = 1;
    localparam int FLG_CARRY = 2;
    localparam int FLG_OVF   = 3;
    localparam int FLG_DZ    = 4;
    localparam int FLG_W     = 5;

    // Division by zero bypasses the iterative unit and completes in one cycle.
    function automatic logic is_multicycle(input logic [3:0] op, input logic b_is_zero);
        return (op == OP_MUL) || ((op == OP_DIV) && !b_is_zero);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [3:0]   i_op,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_done,
    output logic [W-1:0] o_lo,
    output logic [W-1:0] o_hi
);

    localparam int CW = $clog2(W);

    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_div;
    logic [W-1:0]  r_lo;
    logic [W-1:0]  r_hi;
    logic [W-1:0]  r_b;

    logic [W-1:0]  w_lo_nxt;
    logic [W-1:0]  w_hi_nxt;
    logic [W:0]    w_sum;
    logic [W:0]    w_rem_sh;
    logic [W:0]    w_trial;

    // r_hi holds the partial product (mul) or running remainder (div);
    // r_lo holds the multiplier being consumed (mul) or quotient being built (div).
    always_comb begin
        w_lo_nxt = r_lo;
        w_hi_nxt = r_hi;
        w_sum    = '0;
        w_rem_sh = '0;
        w_trial  = '0;
        if (r_div) begin
            w_rem_sh = {r_hi, r_lo[W-1]};
            w_trial  = w_rem_sh - {1'b0, r_b};
            if (!w_trial[W]) begin
                w_hi_nxt = w_trial[W-1:0];
                w_lo_nxt = {r_lo[W-2:0], 1'b1};
            end else begin
                w_hi_nxt = w_rem_sh[W-1:0];
                w_lo_nxt = {r_lo[W-2:0], 1'b0};
            end
        end else begin
            w_sum                = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
            {w_hi_nxt, w_lo_nxt} = {w_sum, r_lo[W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_div  <= 1'b0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= CW'(W - 1);
            r_div  <= (i_op == OP_DIV);
        end else if (r_busy) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_start) begin
            r_lo <= i_a;
            r_hi <= '0;
            r_b  <= i_b;
        end else if (r_busy) begin
            r_lo <= w_lo_nxt;
            r_hi <= w_hi_nxt;
        end
    end

    // The final step's result is presented combinationally so the caller
    // can register it on the same edge the last iteration completes.
    assign o_done = r_busy && (r_cnt == '0);
    assign o_lo   = w_lo_nxt;
    assign o_hi   = w_hi_nxt;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus iterative mul/div,
// with a held result and status flags.
module alu_seq
    import alu_pkg::*;
#(
    parameter int W = 8,
    localparam int SHW = $clog2(W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    input  logic [3:0]       ALU_Sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     ALU_Out,
    output logic [W-1:0]     ALU_Out_hi,
    output logic [FLG_W-1:0] flags
);

    if ((W < 4) || ((W & (W - 1)) != 0)) begin : g_w_check
        $error("alu_seq: W must be a power of two and at least 4");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_op;
    logic [W-1:0]     r_out;
    logic [W-1:0]     r_out_hi;
    logic [FLG_W-1:0] r_flags;

    logic             w_accept;
    logic             w_slow;
    logic [SHW-1:0]   w_amt;
    logic [W:0]       w_sum;
    logic [W:0]       w_diff;
    logic [W:0]       w_shl;
    logic [W:0]       w_shr;
    logic [W-1:0]     w_rol;
    logic [W-1:0]     w_ror;
    logic [W-1:0]     w_fast_lo;
    logic [W-1:0]     w_fast_hi;
    logic             w_fast_c;
    logic             w_fast_v;
    logic             w_fast_dz;
    logic [FLG_W-1:0] w_fast_flags;
    logic [FLG_W-1:0] w_md_flags;
    logic             w_md_done;
    logic [W-1:0]     w_md_lo;
    logic [W-1:0]     w_md_hi;

    function automatic logic [FLG_W-1:0] mk_flags(input logic [W-1:0] res, input logic c,
                                                  input logic v, input logic dz);
        logic [FLG_W-1:0] f;
        f            = '0;
        f[FLG_ZERO]  = (res == '0);
        f[FLG_NEG]   = res[W-1];
        f[FLG_CARRY] = c;
        f[FLG_OVF]   = v;
        f[FLG_DZ]    = dz;
        return f;
    endfunction

    assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign out_valid = (r_state == ST_DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_slow    = is_multicycle(ALU_Sel, B == '0);

    assign w_amt  = B[SHW-1:0];
    assign w_sum  = {1'b0, A} + {1'b0, B};
    assign w_diff = {1'b0, A} - {1'b0, B};
    // The extra bit of each shift catches the last bit shifted out.
    assign w_shl  = {1'b0, A} << w_amt;
    assign w_shr  = {A, 1'b0} >> w_amt;

    // Indices are SHW bits wide, so they wrap modulo W as a rotate needs.
    always_comb begin
        w_rol = '0;
        w_ror = '0;
        for (int i = 0; i < W; i++) begin
            w_rol[i] = A[SHW'(i) - w_amt];
            w_ror[i] = A[SHW'(i) + w_amt];
        end
    end

    always_comb begin
        w_fast_lo = '0;
        w_fast_hi = '0;
        w_fast_c  = 1'b0;
        w_fast_v  = 1'b0;
        w_fast_dz = 1'b0;
        case (ALU_Sel)
            OP_ADD: begin
                w_fast_lo = w_sum[W-1:0];
                w_fast_c  = w_sum[W];
                w_fast_v  = (A[W-1] == B[W-1]) && (w_sum[W-1] != A[W-1]);
            end
            OP_SUB: begin
                w_fast_lo = w_diff[W-1:0];
                w_fast_c  = w_diff[W];
                w_fast_v  = (A[W-1] != B[W-1]) && (w_diff[W-1] != A[W-1]);
            end
            OP_NOTA: w_fast_lo = ~A;
            OP_NOTB: w_fast_lo = ~B;
            OP_XOR:  w_fast_lo = A ^ B;
            OP_OR:   w_fast_lo = A | B;
            OP_AND:  w_fast_lo = A & B;
            OP_DIV: begin
                w_fast_lo = '1;
                w_fast_hi = A;
                w_fast_dz = 1'b1;
            end
            OP_SHL: begin
                w_fast_lo = w_shl[W-1:0];
                w_fast_c  = w_shl[W];
            end
            OP_SHR: begin
                w_fast_lo = w_shr[W:1];
                w_fast_c  = w_shr[0];
            end
            OP_ROL: begin
                w_fast_lo = w_rol;
                w_fast_c  = (w_amt != '0) && w_rol[0];
            end
            OP_ROR: begin
                w_fast_lo = w_ror;
                w_fast_c  = (w_amt != '0) && w_ror[W-1];
            end
            default: ;
        endcase
    end

    assign w_fast_flags = mk_flags(w_fast_lo, w_fast_c, w_fast_v, w_fast_dz);
    assign w_md_flags   = mk_flags(w_md_lo, (r_op == OP_MUL) && (w_md_hi != '0), 1'b0, 1'b0);

    alu_seq_muldiv #(
        .W(W)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .i_start(w_accept && w_slow),
        .i_op   (ALU_Sel),
        .i_a    (A),
        .i_b    (B),
        .o_done (w_md_done),
        .o_lo   (w_md_lo),
        .o_hi   (w_md_hi)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_slow ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                if (w_md_done) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_slow ? ST_BUSY : ST_DONE;
                end else if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op <= ALU_Sel;
        end
    end

    // Result registers only load on a fast accept or on mul/div completion,
    // which keeps them stable while a result waits for out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out    <= '0;
            r_out_hi <= '0;
            r_flags  <= '0;
        end else if (w_accept && !w_slow) begin
            r_out    <= w_fast_lo;
            r_out_hi <= w_fast_hi;
            r_flags  <= w_fast_flags;
        end else if (w_md_done) begin
            r_out    <= w_md_lo;
            r_out_hi <= w_md_hi;
            r_flags  <= w_md_flags;
        end
    end

    assign ALU_Out    = r_out;
    assign ALU_Out_hi = r_out_hi;
    assign flags      = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed cases plus randomized ops checked
// against an arithmetic reference model.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     A = '0;
    logic [W-1:0]     B = '0;
    logic [3:0]       ALU_Sel = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     ALU_Out;
    logic [W-1:0]     ALU_Out_hi;
    logic [FLG_W-1:0] flags;

    alu_seq #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ALU_Sel   (ALU_Sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALU_Out   (ALU_Out),
        .ALU_Out_hi(ALU_Out_hi),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic [4:0] fl;
        int         lat;
        int         acc;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
    endtask

    // Reference: plain integer arithmetic on the opcode's meaning.
    function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t        e;
        int unsigned ai = a;
        int unsigned bi = b;
        int unsigned r  = 0;
        int unsigned h  = 0;
        int unsigned p;
        int unsigned n  = b % W;
        int          sa = $signed(a);
        int          sb = $signed(b);
        int          s;
        bit          c  = 0;
        bit          v  = 0;
        bit          dz = 0;
        e.lat = 1;
        e.acc = 0;
        case (op)
            4'h2: begin r = ai + bi; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
            4'h3: begin r = ai - bi; c = (ai < bi); s = sa - sb; v = (s > 127) || (s < -128); end
            4'h4: r = ~ai;
            4'h5: r = ~bi;
            4'h6: r = ai ^ bi;
            4'h7: r = ai | bi;
            4'h8: r = ai & bi;
            4'h9: begin p = ai * bi; r = p; h = p >> 8; c = (h != 0); e.lat = W + 1; end
            4'hA: begin
                if (bi == 0) begin r = 255; h = ai; dz = 1; end
                else begin r = ai / bi; h = ai % bi; e.lat = W + 1; end
            end
            4'hB: begin r = ai << n; c = (n != 0) && (((ai >> (W - n)) & 1) != 0); end
            4'hC: begin r = ai >> n; c = (n != 0) && (((ai >> (n - 1)) & 1) != 0); end
            4'hD: begin r = ((ai << n) | (ai >> (W - n))) & 255; c = (n != 0) && ((r & 1) != 0); end
            4'hE: begin r = ((ai >> n) | (ai << (W - n))) & 255; c = (n != 0) && (((r >> 7) & 1) != 0); end
            default: r = 0;
        endcase
        r    = r & 255;
        e.lo = r[7:0];
        e.hi = h[7:0];
        e.fl = {dz, v, c, r[7], (r == 0)};
        return e;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output int acc);
        int   waited = 0;
        exp_t e;
        ALU_Sel  = op;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        acc      = -1;
        while (acc < 0) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cyc;
            end else if (++waited > 40) begin
                fail_now("accept_timeout");
                break;
            end
        end
        if (acc >= 0) begin
            e     = model(op, a, b);
            e.acc = acc;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        out_ready = 1'b1;
        while ((sbq.size() != 0) && (w < 60)) begin
            @(negedge clk);
            w++;
        end
        if (sbq.size() != 0) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_lo"}, ALU_Out, 0);
        chk({tag, "_hi"}, ALU_Out_hi, 0);
        chk({tag, "_flags"}, flags, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    // Monitor: latency on first presentation, data on consumption, stability under backpressure.
    bit               seen = 0;
    bit               hold = 0;
    logic [W-1:0]     s_lo;
    logic [W-1:0]     s_hi;
    logic [FLG_W-1:0] s_fl;

    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            seen = 0;
            hold = 0;
        end else begin
            if (hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_lo", ALU_Out, s_lo);
                chk("hold_hi", ALU_Out_hi, s_hi);
                chk("hold_flags", flags, s_fl);
            end
            hold = 0;
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: got %0h, required no result (cycle %0d)", ALU_Out, cyc);
                end else begin
                    if (!seen) begin
                        chk("latency", cyc - sbq[0].acc, sbq[0].lat);
                        seen = 1;
                    end
                    if (out_ready) begin
                        chk("result_lo", ALU_Out, sbq[0].lo);
                        chk("result_hi", ALU_Out_hi, sbq[0].hi);
                        chk("result_flags", flags, sbq[0].fl);
                        void'(sbq.pop_front());
                        seen = 0;
                    end else begin
                        chk("stall_in_ready", in_ready, 0);
                        hold = 1;
                        s_lo = ALU_Out;
                        s_hi = ALU_Out_hi;
                        s_fl = flags;
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int raise_cyc;
        logic [3:0] op;
        logic [7:0] ra;
        logic [7:0] rb;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset("rst_init");
        @(posedge clk);
        #1;

        // Reset in the middle of a multiply.
        issue(OP_MUL, 8'h12, 8'h34, acc);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset("rst_mid_mul");
        @(posedge clk);
        #1;
        issue(OP_ADD, 8'd3, 8'd4, acc);

        // Back-to-back fast ops.
        issue(OP_ADD, 8'hF0, 8'h20, acc);
        issue(OP_SUB, 8'h05, 8'h07, acc);
        issue(OP_ADD, 8'h7F, 8'h01, acc);

        // Multiply, with in_ready low through every busy cycle.
        issue(OP_MUL, 8'hFF, 8'hFF, acc);
        repeat (W) begin
            @(negedge clk);
            chk("busy_in_ready", in_ready, 0);
            chk("busy_out_valid", out_valid, 0);
        end
        @(posedge clk);
        #1;

        issue(OP_DIV, 8'd100, 8'd7, acc);
        issue(OP_DIV, 8'h55, 8'h00, acc);
        drain();

        // Backpressure on an xor result, then same-cycle accept on release.
        out_ready = 1'b0;
        issue(OP_XOR, 8'h5A, 8'h0F, acc);
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        raise_cyc = cyc;
        issue(OP_AND, 8'hC3, 8'h3C, acc);
        chk("bp_release_accept", acc, raise_cyc);

        // Shifts, rotates and the unused opcode.
        issue(OP_ROL, 8'h81, 8'h01, acc);
        issue(OP_SHR, 8'h01, 8'h01, acc);
        issue(OP_SHL, 8'hA5, 8'h08, acc);
        issue(OP_ROR, 8'h3C, 8'h10, acc);
        issue(4'hF, 8'h12, 8'h34, acc);
        drain();

        // Randomized ops with random consumer stalls.
        repeat (300) begin
            repeat ($urandom_range(0, 3)) begin
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
            out_ready = 1'b1;
            op = 4'($urandom_range(0, 15));
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ((op == OP_DIV) && ($urandom_range(0, 3) == 0)) rb = 8'h00;
            issue(op, ra, rb, acc);
        end
        drain();
        chk("scoreboard_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
